// File: rtl/uart_rx_dispatch.sv
// Receive-side dispatcher: buffers UART words in a FIFO, offers the head word to the
// client named by its destination field, and drops it if the client stalls too long.
module uart_rx_dispatch #(
   parameter int DEPTH     = 4,
   parameter int TIMEOUT   = 1024,
   parameter int ERR_CNT_W = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [8:0]             rx_data,
   input  logic                   rx_done,
   input  logic                   rx_framing_error,
   output logic [3:0]             client_valid,
   output logic [6:0]             client_data,
   input  logic [3:0]             client_ready,
   output logic                   timeout_drop,
   output logic                   overflow,
   output logic [ERR_CNT_W-1:0]   err_count,
   output logic [$clog2(DEPTH):0] fifo_count,
   input  logic                   clear_status
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_OFFER, S_DROP} state_t;

   state_t               state_q;
   logic [ST_W-1:0]      stall_q;
   logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [8:0]           mem_q [DEPTH];
   logic                 fe_q;
   logic                 overflow_q;
   logic [ERR_CNT_W-1:0] err_q;

   logic [8:0] head;
   logic [1:0] head_id;
   logic       offer, accept, pop, push;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign head    = mem_q[rd_ptr_q];
   assign head_id = head[8:7];
   assign offer   = (state_q == S_OFFER);
   // Only the addressed client's ready bit can complete the transfer.
   assign accept  = offer && client_ready[head_id];
   assign pop     = accept || (state_q == S_DROP);
   assign push    = rx_done && ((count_q != CNT_W'(DEPTH)) || pop);

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
   end

   // Storage is data only; it needs no reset since count_q gates every read.
   always_ff @(posedge clock) begin
      if (push)
         mem_q[wr_ptr_q] <= rx_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         stall_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               stall_q <= '0;
               if (count_q != '0)
                  state_q <= S_OFFER;
            end
            S_OFFER: begin
               if (accept) begin
                  stall_q <= '0;
                  state_q <= (count_d != '0) ? S_OFFER : S_IDLE;
               end else if (stall_q == ST_W'(TIMEOUT - 1)) begin
                  stall_q <= '0;
                  state_q <= S_DROP;
               end else begin
                  stall_q <= stall_q + 1'b1;
               end
            end
            S_DROP: begin
               stall_q <= '0;
               state_q <= S_IDLE;
            end
            default: begin
               stall_q <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Status: clear_status takes priority over any set or increment in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         fe_q       <= 1'b0;
         overflow_q <= 1'b0;
         err_q      <= '0;
      end else begin
         fe_q <= rx_framing_error;
         if (clear_status) begin
            overflow_q <= 1'b0;
            err_q      <= '0;
         end else begin
            if (rx_done && !push)
               overflow_q <= 1'b1;
            if (rx_framing_error && !fe_q)
               err_q <= sat_inc(err_q);
         end
      end
   end

   assign client_valid = offer ? (4'b0001 << head_id) : 4'b0000;
   assign client_data  = offer ? head[6:0] : 7'd0;
   assign timeout_drop = (state_q == S_DROP);
   assign overflow     = overflow_q;
   assign err_count    = err_q;
   assign fifo_count   = count_q;

endmodule

// File: tb/tb_uart_rx_dispatch.sv
// Directed bench for uart_rx_dispatch: a per-cycle vector table plus hand-written
// sequences for framing-error counting and reset during an active offer.
module tb_uart_rx_dispatch;

   logic       clock = 1'b0;
   logic       reset;
   logic [8:0] rx_data;
   logic       rx_done;
   logic       rx_framing_error;
   logic [3:0] client_valid;
   logic [6:0] client_data;
   logic [3:0] client_ready;
   logic       timeout_drop;
   logic       overflow;
   logic [7:0] err_count;
   logic [2:0] fifo_count;
   logic       clear_status;

   int errors = 0;
   int checks = 0;

   uart_rx_dispatch #(.DEPTH(4), .TIMEOUT(8), .ERR_CNT_W(8)) dut (
      .clock(clock), .reset(reset),
      .rx_data(rx_data), .rx_done(rx_done), .rx_framing_error(rx_framing_error),
      .client_valid(client_valid), .client_data(client_data), .client_ready(client_ready),
      .timeout_drop(timeout_drop), .overflow(overflow), .err_count(err_count),
      .fifo_count(fifo_count), .clear_status(clear_status)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       done;
      logic [8:0] data;
      logic [3:0] rdy;
      logic       clr;
      logic [3:0] e_valid;
      logic [6:0] e_data;
      logic [2:0] e_cnt;
      logic       e_drop;
      logic       e_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic done, input logic [8:0] data, input logic [3:0] rdy,
                      input logic clr, input logic [3:0] ev, input logic [6:0] ed,
                      input logic [2:0] ec, input logic edrop, input logic eovf);
      vec_t v;
      v.done = done; v.data = data; v.rdy = rdy; v.clr = clr;
      v.e_valid = ev; v.e_data = ed; v.e_cnt = ec; v.e_drop = edrop; v.e_ovf = eovf;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; rx_data = '0; rx_done = 1'b0; rx_framing_error = 1'b0;
      client_ready = '0; clear_status = 1'b0;
      repeat (3) step();

      chk("reset valid", client_valid, 0);
      chk("reset data", client_data, 0);
      chk("reset drop", timeout_drop, 0);
      chk("reset ovf", overflow, 0);
      chk("reset err", err_count, 0);
      chk("reset count", fifo_count, 0);
      reset = 1'b0;

      // Single word for client 2
      add(1, 9'h12A, 4'h0, 0, 4'b0000, 7'h00, 1, 0, 0);
      add(0, 9'h000, 4'h0, 0, 4'b0100, 7'h2A, 1, 0, 0);
      add(0, 9'h000, 4'h4, 0, 4'b0000, 7'h00, 0, 0, 0);
      add(0, 9'h000, 4'h0, 0, 4'b0000, 7'h00, 0, 0, 0);
      // Back-to-back delivery to clients 0..3
      add(1, 9'h011, 4'hF, 0, 4'b0000, 7'h00, 1, 0, 0);
      add(1, 9'h0A2, 4'hF, 0, 4'b0001, 7'h11, 2, 0, 0);
      add(1, 9'h133, 4'hF, 0, 4'b0010, 7'h22, 2, 0, 0);
      add(1, 9'h1C4, 4'hF, 0, 4'b0100, 7'h33, 2, 0, 0);
      add(0, 9'h000, 4'hF, 0, 4'b1000, 7'h44, 1, 0, 0);
      add(0, 9'h000, 4'hF, 0, 4'b0000, 7'h00, 0, 0, 0);
      // Fill, overflow, push coincident with pop at full, drain, clear
      add(1, 9'h001, 4'h0, 0, 4'b0000, 7'h00, 1, 0, 0);
      add(1, 9'h082, 4'h0, 0, 4'b0001, 7'h01, 2, 0, 0);
      add(1, 9'h103, 4'h0, 0, 4'b0001, 7'h01, 3, 0, 0);
      add(1, 9'h184, 4'h0, 0, 4'b0001, 7'h01, 4, 0, 0);
      add(1, 9'h055, 4'h0, 0, 4'b0001, 7'h01, 4, 0, 1);
      add(1, 9'h0E6, 4'h1, 0, 4'b0010, 7'h02, 4, 0, 1);
      add(0, 9'h000, 4'hF, 0, 4'b0100, 7'h03, 3, 0, 1);
      add(0, 9'h000, 4'hF, 0, 4'b1000, 7'h04, 2, 0, 1);
      add(0, 9'h000, 4'hF, 0, 4'b0010, 7'h66, 1, 0, 1);
      add(0, 9'h000, 4'hF, 0, 4'b0000, 7'h00, 0, 0, 1);
      add(0, 9'h000, 4'h0, 1, 4'b0000, 7'h00, 0, 0, 0);
      // Timeout: client 1 head, only ready[0] asserted
      add(1, 9'h08A, 4'h1, 0, 4'b0000, 7'h00, 1, 0, 0);
      add(1, 9'h10B, 4'h1, 0, 4'b0010, 7'h0A, 2, 0, 0);
      for (int k = 0; k < 7; k++)
         add(0, 9'h000, 4'h1, 0, 4'b0010, 7'h0A, 2, 0, 0);
      add(0, 9'h000, 4'h1, 0, 4'b0000, 7'h00, 2, 1, 0);
      add(0, 9'h000, 4'h1, 0, 4'b0000, 7'h00, 1, 0, 0);
      add(0, 9'h000, 4'h1, 0, 4'b0100, 7'h0B, 1, 0, 0);
      add(0, 9'h000, 4'h4, 0, 4'b0000, 7'h00, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rx_done = vecs[i].done; rx_data = vecs[i].data;
         client_ready = vecs[i].rdy; clear_status = vecs[i].clr;
         step();
         chk($sformatf("vec%0d valid", i), client_valid, vecs[i].e_valid);
         chk($sformatf("vec%0d data", i), client_data, vecs[i].e_data);
         chk($sformatf("vec%0d count", i), fifo_count, vecs[i].e_cnt);
         chk($sformatf("vec%0d drop", i), timeout_drop, vecs[i].e_drop);
         chk($sformatf("vec%0d ovf", i), overflow, vecs[i].e_ovf);
      end
      rx_done = 1'b0; client_ready = '0; clear_status = 1'b0;

      // Framing-error counter saturation
      for (int i = 0; i < 300; i++) begin
         rx_framing_error = 1'b1; step();
         rx_framing_error = 1'b0; step();
      end
      chk("err saturate", err_count, 255);
      rx_framing_error = 1'b1; clear_status = 1'b1; step();
      chk("err clear wins", err_count, 0);
      rx_framing_error = 1'b0; clear_status = 1'b0; step();
      chk("err after clear", err_count, 0);
      rx_framing_error = 1'b1;
      repeat (5) step();
      chk("err level once", err_count, 1);
      rx_framing_error = 1'b0; step();

      // Reset during an active offer with three words buffered
      rx_done = 1'b1;
      rx_data = 9'h181; step();
      rx_data = 9'h002; step();
      rx_data = 9'h083; step();
      rx_done = 1'b0;
      chk("pre-reset valid", client_valid, 4'b1000);
      chk("pre-reset count", fifo_count, 3);
      reset = 1'b1; step();
      chk("mid reset valid", client_valid, 0);
      chk("mid reset count", fifo_count, 0);
      chk("mid reset err", err_count, 0);
      reset = 1'b0;
      rx_done = 1'b1; rx_data = 9'h1DA; step();
      rx_done = 1'b0;
      chk("post-reset count", fifo_count, 1);
      chk("post-reset idle", client_valid, 0);
      step();
      chk("post-reset valid", client_valid, 4'b1000);
      chk("post-reset data", client_data, 7'h5A);
      client_ready = 4'b1000; step();
      chk("post-reset drained", fifo_count, 0);
      chk("post-reset valid off", client_valid, 0);
      client_ready = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
